// File: rtl/varredura_tabela.sv
// varredura_tabela: sweeps the 16 {a,b,c,d} vectors, holds each SETTLE+1 cycles and captures s into tabela.
// Optional one-counter on port uns is enabled by defining VARREDURA_CONTA_EN.
module varredura_tabela #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        s,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic [15:0] tabela,
    output logic [3:0]  vetor,
    output logic        busy,
`ifdef VARREDURA_CONTA_EN
    output logic [4:0]  uns,
`endif
    output logic        done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t     state, nxt;
    logic [3:0] cnt;
    logic       aceita, amostra;
    always_comb begin
        aceita  = start && state != RUN;
        amostra = state == RUN && cnt == 4'(SETTLE);
        nxt     = aceita ? RUN : state == DONE ? IDLE : amostra && vetor == 4'd15 ? DONE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            vetor  <= '0;
            cnt    <= '0;
            tabela <= '0;
        end else begin
            state <= nxt;
            if (aceita) begin
                vetor  <= '0;
                cnt    <= '0;
                tabela <= '0;
            end else if (amostra) begin
                tabela[vetor] <= s;
                cnt           <= '0;
                vetor         <= vetor + 4'd1;
            end else if (state == RUN) begin
                cnt <= cnt + 4'd1;
            end
        end
    end
`ifdef VARREDURA_CONTA_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) uns <= '0;
        else if (aceita) uns <= '0;
        else if (amostra) uns <= uns + {4'd0, s};
    end
`endif
    // vetor wraps 15 -> 0 on the final sample, so the drivers read 0000 in DONE and IDLE
    assign {a, b, c, d} = vetor;
    assign busy = state == RUN;
    assign done = state == DONE;
endmodule

// File: tb/tb_varredura_tabela.sv
// tb_varredura_tabela: three DUTs (SETTLE 2, 0, 15) driven one at a time; scoreboard monitor checks
// every cycle against sweep timing and truth tables computed from the selected block function.
module tb_varredura_tabela;
    localparam int SV [3] = '{2, 0, 15};
    logic clk = 1'b0;
    logic rst_n, st;
    logic [2:0] av, bv, cv, dv, sv, busyv, donev;
    logic [15:0] tabv [3];
    logic [3:0] vetv [3];
    logic [4:0] unsv [3];
    int sel, mode, cyc = 0, nchk = 0, npass = 0;
    logic [15:0] rt;
    logic [15:0] last_tab [3];
    typedef struct {int k; int dc; logic [15:0] tab; int u;} exp_t;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic fn(input int m, input logic [15:0] r, input logic [3:0] v);
        return m == 0 ? (v[3] & v[2]) | v[1] : m == 1 ? ^v : m == 2 ? 1'b0 : m == 3 ? 1'b1 : r[v];
    endfunction

    function automatic logic [15:0] tab_of(input int m, input logic [15:0] r);
        logic [15:0] t;
        for (int i = 0; i < 16; i++) t[i] = fn(m, r, 4'(i));
        return t;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gd
        assign sv[g] = fn(mode, rt, {av[g], bv[g], cv[g], dv[g]});
        varredura_tabela #(.SETTLE(SV[g])) u (
            .clk(clk), .rst_n(rst_n), .start(st && sel == g), .s(sv[g]),
            .a(av[g]), .b(bv[g]), .c(cv[g]), .d(dv[g]),
            .tabela(tabv[g]), .vetor(vetv[g]), .busy(busyv[g]),
`ifdef VARREDURA_CONTA_EN
            .uns(unsv[g]),
`endif
            .done(donev[g])
        );
`ifndef VARREDURA_CONTA_EN
        assign unsv[g] = '0;
`endif
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d, dut %0d)", n, act, exp, cyc, sel);
        else npass++;
    endtask

    task automatic push_at(input int k);
        exp_t e;
        e.k = k;
        e.dc = k + 16 * (SV[sel] + 1);
        e.tab = tab_of(mode, rt);
        e.u = $countones(e.tab);
        q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic begin_sweep(output int k);
        k = cyc + 1;
        push_at(k);
        st = 1'b1;
        @(posedge clk);
        #2 st = 1'b0;
    endtask

    task automatic sweep(input int sl, input int m);
        int k;
        sel = sl;
        mode = m;
        begin_sweep(k);
        wait_until(k + 16 * (SV[sl] + 1) + 1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_tabela", tabv[sel], 0);
        chk("rst_busy", busyv[sel], 0);
        chk("rst_done", donev[sel], 0);
        chk("rst_vetor", vetv[sel], 0);
        chk("rst_abcd", {av[sel], bv[sel], cv[sel], dv[sel]}, 0);
        chk("rst_uns", unsv[sel], 0);
    endtask

    always @(negedge clk) begin : mon
        int j;
        logic [15:0] mask;
        if (rst_n) begin
            if (q.size() > 0 && cyc == q[0].dc) begin
                chk("done", donev[sel], 1);
                chk("busy_at_done", busyv[sel], 0);
                chk("vetor_at_done", vetv[sel], 0);
                chk("tabela", tabv[sel], q[0].tab);
`ifdef VARREDURA_CONTA_EN
                chk("uns", unsv[sel], q[0].u);
`endif
                last_tab[sel] = q[0].tab;
                void'(q.pop_front());
            end else begin
                chk("done_low", donev[sel], 0);
                if (q.size() > 0 && cyc >= q[0].k) begin
                    j = (cyc - q[0].k) / (SV[sel] + 1);
                    mask = 16'((32'd1 << j) - 1);
                    chk("busy", busyv[sel], 1);
                    chk("vetor", vetv[sel], j);
                    chk("abcd", {av[sel], bv[sel], cv[sel], dv[sel]}, j);
                    chk("tabela_partial", tabv[sel], q[0].tab & mask);
                end else begin
                    chk("busy_idle", busyv[sel], 0);
                    chk("abcd_idle", {av[sel], bv[sel], cv[sel], dv[sel]}, 0);
                    chk("tabela_hold", tabv[sel], last_tab[sel]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        rst_n = 1'b0;
        st = 1'b0;
        sel = 0;
        mode = 2;
        rt = '0;
        last_tab = '{default: '0};
        #1;
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1 chk_reset_outputs();
        end
        sel = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;
        sweep(0, 0);
        sweep(1, 1);
        sweep(2, 2);
        sweep(2, 3);
        // a start pulse while vector 5 is driven must be ignored
        sel = 0;
        mode = 4;
        rt = 16'($urandom);
        begin_sweep(k);
        wait_until(k + 5 * (SV[0] + 1) + 1);
        st = 1'b1;
        @(posedge clk);
        #2 st = 1'b0;
        wait_until(k + 16 * (SV[0] + 1) + 1);
        // start held high: three sweeps separated by a single DONE cycle
        sel = 1;
        rt = 16'($urandom);
        k = cyc + 1;
        for (int i = 0; i < 3; i++) push_at(k + i * (16 * (SV[1] + 1) + 1));
        st = 1'b1;
        wait_until(k + 2 * (16 * (SV[1] + 1) + 1) + 2);
        st = 1'b0;
        wait_until(k + 3 * (16 * (SV[1] + 1) + 1) + 1);
        // asynchronous abort at vector 7
        sel = 0;
        rt = 16'($urandom);
        begin_sweep(k);
        wait_until(k + 7 * (SV[0] + 1) + 1);
        chk("vetor_before_abort", vetv[0], 7);
        rst_n = 1'b0;
        #1 chk_reset_outputs();
        q.delete();
        last_tab = '{default: '0};
        @(posedge clk);
        #2 rst_n = 1'b1;
        wait_until(cyc + 16 * (SV[0] + 1) + 4);
        for (int i = 0; i < 6; i++) begin
            rt = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #2 sweep($urandom_range(0, 2), $urandom_range(0, 4));
        end
        repeat (3) @(posedge clk);
        #2 chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/varredura_tabela.md
# varredura_tabela

Sequential stimulus generator and capture stage that sits directly upstream of a 4-input combinational block under test (inputs a, b, c, d; output s). On a start request it drives all 16 input combinations in ascending order and holds each one for a programmable settle time. It samples the block's output s for each combination and assembles the complete 16-bit truth table, so lab exercises can be checked in hardware rather than by reading simulation printouts.

## Interface
- SETTLE, default 2: extra cycles each vector is held before s is sampled; legal range 0..15.

- clk  in  1  system clock, rising-edge active
- rst_n  in  1  asynchronous active-low reset
- start  in  1  sweep request, sampled on rising clk edge
- a  out  1  input a to block under test, vector bit 3 (MSB)
- b  out  1  input b, vector bit 2
- c  out  1  input c, vector bit 1
- d  out  1  input d, vector bit 0 (LSB)
- s  in  1  output of block under test
- tabela  out  16  truth table; bit i = s observed with {a,b,c,d} = i
- vetor  out  4  index of the vector currently driven; equals {a,b,c,d}
- busy  out  1  high while the sweep is in progress
- done  out  1  one-cycle pulse when tabela is complete
- uns  out  5  number of 1s in tabela (only with VARREDURA_CONTA_EN)

## Operation
- States:
  - IDLE: after reset.
  - RUN: sweep in progress.
  - DONE: one cycle only, then IDLE.
- IDLE/DONE with start=1:
  - On the next edge, go to RUN.
  - Set vetor to 0, hold counter cnt to 0, tabela to 16'h0000.
- RUN, each edge with cnt < SETTLE: cnt increments.
- RUN, edge with cnt == SETTLE:
  - tabela[vetor] <= s; cnt <= 0.
  - If vetor == 15: go to DONE and set vetor to 0.
  - Otherwise: vetor increments by 1.
- RUN with start=1: ignored. No restart and no effect on tabela.
- DONE: done=1 and busy=0. Next state is IDLE, or RUN if start=1 in that cycle (back-to-back sweeps).
- tabela holds its value through IDLE. It clears only when a new sweep is accepted.
- a, b, c, d are registered and always equal vetor. They are 0000 in IDLE and DONE.
- cnt is 4 bits wide. The comparison is against SETTLE, with no wrap beyond 15.
- s is assumed combinationally stable within SETTLE+1 cycles of a vector change. There is no synchronizer on s.

## Timing
- Reset values while rst_n=0, asynchronous:
  - state IDLE; vetor=0; a=b=c=d=0; cnt=0.
  - tabela=16'h0000; busy=0; done=0; uns=0.
- Let start be accepted at edge k.
  - busy=1 from edge k until edge k+16*(SETTLE+1).
  - Vector j is driven from edge k+j*(SETTLE+1) and sampled at edge k+(j+1)*(SETTLE+1).
- done=1 for exactly one cycle following edge k+16*(SETTLE+1).
  - tabela is final in that cycle and remains stable afterwards.
- Total latency from start to done: 16*(SETTLE+1) cycles. With SETTLE=0 this is 16 cycles.
- Mid-sweep rst_n assertion aborts immediately. All outputs go to their reset values, with no done pulse. Any deassertion timing is allowed.
- start held high continuously: sweeps repeat. Each sweep is separated by exactly one DONE cycle.

## Configuration
- VARREDURA_CONTA_EN defined:
  - Port uns is present.
  - uns increments on each RUN sample edge where s=1 and clears when a sweep is accepted or on reset.
  - uns equals popcount(tabela) at done.
- Not defined: port uns and its counter are absent. All other behaviour is identical.

## Test plan
- Reset mid-sweep: assert rst_n=0 at vector 7 -> tabela=0000, busy=0, a..d=0000 immediately; no done pulse.
- Model s=(a&b)|c, SETTLE=2, single start pulse -> done exactly 48 cycles after start; tabela=16'hFCCC; uns=10.
- Model s=a^b^c^d, SETTLE=0 -> done 16 cycles after start; tabela=16'h6996; uns=8; each vector held exactly 1 cycle.
- Model s=0, then s=1, SETTLE=15 -> tabela=16'h0000 then 16'hFFFF; 256 cycles each; vetor sequence 0..15 with each value held 16 cycles.
- start pulsed at vector 5, and start held high across DONE -> mid-sweep pulse has no effect; second sweep starts the cycle after done with tabela cleared; gap between sweeps is exactly one cycle.
